aux_bus_bridge: RTL and testbench

AUX_BUS_BRIDGE -- requirements
Module: aux_bus_bridge

---
 rtl/aux_pkg.sv | 15 +
 rtl/aux_bus_bridge_if.sv | 18 +
 rtl/aux_req_fifo.sv | 32 +++
 rtl/aux_bus_bridge.sv | 99 +++++++++
 tb/tb_aux_bus_bridge.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/aux_pkg.sv
// aux_pkg: shared types and constants for the aux bus bridge
package aux_pkg;
  localparam logic [15:0] AUX_REGION_BASE = 16'hE000;
  localparam logic [31:0] AUX_ERR_RDATA = 32'hFFFF_FFFF;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESPOND} aux_state_e;
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } aux_req_t;
  function automatic logic aux_mapped(input logic [31:0] addr);
    return addr[31:16] == AUX_REGION_BASE;
  endfunction
endpackage

// File: rtl/aux_bus_bridge_if.sv
// aux_bus_bridge_if: CPU-side and peripheral-side aux bus bundles
interface aux_cpu_if;
  logic        request, write, abort, rvalid;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  wstrb;
  logic [8:0]  rtag;
  modport master (output request, addr, write, wstrb, wdata, abort, input rvalid, rdata, rtag);
  modport slave (input request, addr, write, wstrb, wdata, abort, output rvalid, rdata, rtag);
endinterface

interface aux_periph_if;
  logic        request, write, ready, rvalid;
  logic [3:0]  sel, wstrb;
  logic [11:0] addr;
  logic [31:0] wdata, rdata;
  modport master (output request, sel, addr, write, wstrb, wdata, input ready, rvalid, rdata);
  modport slave (input request, sel, addr, write, wstrb, wdata, output ready, rvalid, rdata);
endinterface

// File: rtl/aux_req_fifo.sv
// aux_req_fifo: synchronous request FIFO with full/empty flags
module aux_req_fifo import aux_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     push_i,
  input  logic     pop_i,
  input  aux_req_t data_i,
  output aux_req_t data_o,
  output logic     full_o,
  output logic     empty_o
);
  localparam int AW = $clog2(DEPTH);
  aux_req_t mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + (AW+1)'(1);
      if (pop_i) rd_q <= rd_q + (AW+1)'(1);
    end
  end
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q[AW-1:0]] <= data_i;
  end
  assign data_o  = mem_q[rd_q[AW-1:0]];
  assign empty_o = wr_q == rd_q;
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
endmodule

// File: rtl/aux_bus_bridge.sv
// aux_bus_bridge: queues CPU aux accesses and issues them one at a time to
// decoded peripheral slots, returning read responses in order.
module aux_bus_bridge import aux_pkg::*; #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  aux_cpu_if.slave     cpu,
  aux_periph_if.master periph,
  input  logic         err_clear_i,
  output logic         err_overflow_o,
  output logic         err_timeout_o
);
  localparam int TW = $clog2(TIMEOUT + 1);
  aux_state_e state_q, state_d;
  aux_req_t s1_q, cur_q, cur_d, head;
  logic s1_valid_q, push, pop, full, empty, ovf_evt, to_evt, ovf_q, to_q;
  logic [31:0] rdata_q, rdata_d;
  logic [TW-1:0] cnt_q, cnt_d;
  // A full FIFO still takes the S1 entry when the FSM pops in the same cycle
  assign push    = s1_valid_q && !cpu.abort && (!full || pop);
  assign ovf_evt = s1_valid_q && !cpu.abort && full && !pop;
  aux_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i, .rst_ni, .push_i(push), .pop_i(pop), .data_i(s1_q),
    .data_o(head), .full_o(full), .empty_o(empty)
  );
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    rdata_d = rdata_q;
    cnt_d   = '0;
    pop     = 1'b0;
    to_evt  = 1'b0;
    case (state_q)
      IDLE: if (!empty) begin
        pop     = 1'b1;
        cur_d   = head;
        rdata_d = '0;
        state_d = aux_mapped(head.addr) ? ISSUE : head.write ? IDLE : RESPOND;
      end
      ISSUE: begin
        cnt_d = cnt_q + TW'(1);
        if (periph.ready) begin
          cnt_d   = '0;
          state_d = cur_q.write ? IDLE : WAIT_RD;
        end else if (cnt_q == TW'(TIMEOUT - 1)) begin
          to_evt  = 1'b1;
          rdata_d = AUX_ERR_RDATA;
          state_d = cur_q.write ? IDLE : RESPOND;
        end
      end
      WAIT_RD: begin
        cnt_d = cnt_q + TW'(1);
        if (periph.rvalid) begin
          rdata_d = periph.rdata;
          state_d = RESPOND;
        end else if (cnt_q == TW'(TIMEOUT - 1)) begin
          to_evt  = 1'b1;
          rdata_d = AUX_ERR_RDATA;
          state_d = RESPOND;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      cur_q      <= '0;
      rdata_q    <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_valid_q <= cpu.request;
      s1_q       <= '{addr: cpu.addr, write: cpu.write, wstrb: cpu.wstrb, wdata: cpu.wdata};
      cur_q      <= cur_d;
      rdata_q    <= rdata_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_evt || (ovf_q && !err_clear_i);
      to_q       <= to_evt || (to_q && !err_clear_i);
    end
  end
  assign periph.request = state_q == ISSUE;
  assign periph.sel     = periph.request ? 4'b0001 << cur_q.addr[13:12] : 4'b0000;
  assign periph.addr    = cur_q.addr[11:0];
  assign periph.write   = cur_q.write;
  assign periph.wstrb   = cur_q.wstrb;
  assign periph.wdata   = cur_q.wdata;
  assign cpu.rvalid     = state_q == RESPOND;
  assign cpu.rdata      = rdata_q;
  assign cpu.rtag       = cur_q.wdata[8:0];
  assign err_overflow_o = ovf_q;
  assign err_timeout_o  = to_q;
endmodule

// File: tb/tb_aux_bus_bridge.sv
// tb_aux_bus_bridge: table vectors, hand sequences and randomized traffic
// checked against a transaction-level model of the bridge.
module tb_aux_bus_bridge;
  logic clk = 1'b0, rst_n = 1'b0, err_clear = 1'b0;
  logic err_ovf, err_to;
  always #5 clk = ~clk;
  aux_cpu_if cpu_if();
  aux_periph_if per_if();
  aux_bus_bridge #(.FIFO_DEPTH(4), .TIMEOUT(255)) dut (
    .clk_i(clk), .rst_ni(rst_n), .cpu(cpu_if), .periph(per_if),
    .err_clear_i(err_clear), .err_overflow_o(err_ovf), .err_timeout_o(err_to)
  );

  typedef struct {logic [3:0] sel; logic [11:0] addr; logic write; logic [3:0] wstrb; logic [31:0] wdata;} acc_t;
  typedef struct {logic [31:0] rdata; logic [8:0] tag;} rsp_t;
  typedef struct {
    logic [31:0] addr; logic w; logic [3:0] s; logic [31:0] d; logic [31:0] prd;
    bit acc; logic [3:0] sel; logic [11:0] pa; bit rsp; logic [31:0] rdata; logic [8:0] tag; int lat;
  } vec_t;

  int tests = 0, fails = 0, cyc = 0, n_acc = 0, n_rsp = 0, req_cycles = 0, pdly_max = 0;
  acc_t exp_acc[$];
  rsp_t exp_rsp[$];
  bit model_en = 1'b0, stall = 1'b0, pr_force = 1'b0;
  logic [31:0] pr_val = '0;
  logic [3:0] last_sel, last_wstrb;
  logic [11:0] last_addr;
  logic [31:0] last_wdata, last_rdata;
  logic [8:0] last_tag;
  int last_rsp_cyc = 0;
  logic pv = 1'b0, pm = 1'b0, pw = 1'b0;
  logic [31:0] pa = '0, pd = '0;
  logic [3:0] ps = '0;
  vec_t tbl[7];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] hsh(input logic [3:0] s, input logic [11:0] a);
    return {s, a, 16'hA5C3};
  endfunction

  // Reference: mapped accesses reach slot addr[13:12]; reads answer with slot data or 0 when unmapped
  task automatic mpush(input logic [31:0] a, input logic w, input logic [3:0] s, input logic [31:0] d);
    acc_t e;
    rsp_t r;
    e = '{4'b0001 << a[13:12], a[11:0], w, s, d};
    r = '{32'h0, d[8:0]};
    if (a[31:16] == 16'hE000) begin
      exp_acc.push_back(e);
      r.rdata = hsh(e.sel, e.addr);
    end
    if (!w) exp_rsp.push_back(r);
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic w, input logic [3:0] s,
                       input logic [31:0] d, input logic ab, input logic m);
    @(negedge clk);
    if (pv && pm && !ab) mpush(pa, pw, ps, pd);
    cpu_if.request = v; cpu_if.addr = a; cpu_if.write = w;
    cpu_if.wstrb = s; cpu_if.wdata = d; cpu_if.abort = ab;
    pv = v; pm = m; pa = a; pw = w; ps = s; pd = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic clear_errors();
    @(negedge clk) err_clear = 1'b1;
    @(negedge clk) err_clear = 1'b0;
    #1;
  endtask

  // Peripheral responder and response monitor
  initial begin
    int icnt, vcnt, rdly, vdly;
    bit pend;
    logic [31:0] pdata;
    icnt = 0; vcnt = 0; rdly = 0; vdly = 0; pend = 1'b0; pdata = '0;
    per_if.ready = 1'b0; per_if.rvalid = 1'b0; per_if.rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin pend = 1'b0; icnt = 0; end
      per_if.ready  = !stall && per_if.request && icnt >= rdly;
      per_if.rvalid = pend && vcnt >= vdly;
      per_if.rdata  = per_if.rvalid ? pdata : 32'h0;
      #1;
      if (per_if.request) req_cycles++;
      if (per_if.rvalid) pend = 1'b0; else if (pend) vcnt++;
      if (per_if.request && per_if.ready) begin
        n_acc++;
        last_sel = per_if.sel; last_addr = per_if.addr;
        last_wstrb = per_if.wstrb; last_wdata = per_if.wdata;
        if (model_en) begin
          check("acc_expected", exp_acc.size() != 0, 1);
          if (exp_acc.size() != 0) begin
            acc_t e;
            e = exp_acc.pop_front();
            check("acc_sel", per_if.sel, e.sel);
            check("acc_addr", per_if.addr, e.addr);
            check("acc_write", per_if.write, e.write);
            if (e.write) begin
              check("acc_wstrb", per_if.wstrb, e.wstrb);
              check("acc_wdata", per_if.wdata, e.wdata);
            end
          end
        end
        if (!per_if.write) begin
          pend = 1'b1; vcnt = 0;
          pdata = pr_force ? pr_val : hsh(per_if.sel, per_if.addr);
        end
        icnt = 0;
        rdly = int'($urandom_range(pdly_max));
        vdly = int'($urandom_range(pdly_max));
      end else icnt = per_if.request ? icnt + 1 : 0;
      if (cpu_if.rvalid) begin
        n_rsp++;
        last_rdata = cpu_if.rdata; last_tag = cpu_if.rtag; last_rsp_cyc = cyc;
        if (model_en) begin
          check("rsp_expected", exp_rsp.size() != 0, 1);
          if (exp_rsp.size() != 0) begin
            rsp_t r;
            r = exp_rsp.pop_front();
            check("rsp_rdata", cpu_if.rdata, r.rdata);
            check("rsp_tag", cpu_if.rtag, r.tag);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a0, r0, q0;
    cpu_if.request = 1'b0; cpu_if.addr = '0; cpu_if.write = 1'b0;
    cpu_if.wstrb = '0; cpu_if.wdata = '0; cpu_if.abort = 1'b0;
    tbl[0] = '{32'hE000_2010, 1'b0, 4'h0, 32'h0000_0005, 32'h1234_5678, 1'b1, 4'b0100, 12'h010, 1'b1, 32'h1234_5678, 9'h005, 5};
    tbl[1] = '{32'h1000_0000, 1'b0, 4'h0, 32'h0000_01FF, 32'h0,         1'b0, 4'b0000, 12'h000, 1'b1, 32'h0,         9'h1FF, 3};
    tbl[2] = '{32'hE000_3ABC, 1'b1, 4'h5, 32'hDEAD_BEEF, 32'h0,         1'b1, 4'b1000, 12'hABC, 1'b0, 32'h0,         9'h000, 0};
    tbl[3] = '{32'h2000_0000, 1'b1, 4'hF, 32'h0000_0001, 32'h0,         1'b0, 4'b0000, 12'h000, 1'b0, 32'h0,         9'h000, 0};
    tbl[4] = '{32'hE000_0FFC, 1'b0, 4'h0, 32'h0000_0100, 32'hCAFE_F00D, 1'b1, 4'b0001, 12'hFFC, 1'b1, 32'hCAFE_F00D, 9'h100, 5};
    tbl[5] = '{32'hE001_1004, 1'b0, 4'h0, 32'h0000_00AA, 32'h5555_5555, 1'b0, 4'b0000, 12'h000, 1'b1, 32'h0,         9'h0AA, 3};
    tbl[6] = '{32'hE000_C123, 1'b0, 4'h0, 32'hFFFF_F033, 32'h0000_0001, 1'b1, 4'b0001, 12'h123, 1'b1, 32'h0000_0001, 9'h033, 5};

    repeat (3) @(negedge clk);
    #1 check("reset_outputs", {cpu_if.rvalid, cpu_if.rdata, cpu_if.rtag, per_if.request, per_if.sel, per_if.addr,
                               per_if.write, per_if.wstrb, per_if.wdata, err_ovf, err_to}, 0);
    @(negedge clk) rst_n = 1'b1;
    idle(2);
    check("post_reset_idle", {cpu_if.rvalid, per_if.request, err_ovf, err_to}, 0);

    for (int i = 0; i < 7; i++) begin
      int t0;
      pr_force = 1'b1; pr_val = tbl[i].prd;
      a0 = n_acc; r0 = n_rsp;
      drive(1'b1, tbl[i].addr, tbl[i].w, tbl[i].s, tbl[i].d, 1'b0, 1'b0);
      t0 = cyc;
      idle(12);
      check($sformatf("vec%0d_acc_count", i), n_acc - a0, tbl[i].acc);
      if (tbl[i].acc) begin
        check($sformatf("vec%0d_sel", i), last_sel, tbl[i].sel);
        check($sformatf("vec%0d_paddr", i), last_addr, tbl[i].pa);
        if (tbl[i].w) check($sformatf("vec%0d_wdata", i), {last_wstrb, last_wdata}, {tbl[i].s, tbl[i].d});
      end
      check($sformatf("vec%0d_rsp_count", i), n_rsp - r0, tbl[i].rsp);
      if (tbl[i].rsp) begin
        check($sformatf("vec%0d_rdata", i), last_rdata, tbl[i].rdata);
        check($sformatf("vec%0d_rtag", i), last_tag, tbl[i].tag);
        check($sformatf("vec%0d_latency", i), last_rsp_cyc - t0, tbl[i].lat);
      end
    end
    pr_force = 1'b0;
    model_en = 1'b1;

    a0 = n_acc; r0 = n_rsp;
    drive(1'b1, 32'hE000_1020, 1'b0, 4'h0, 32'h11, 1'b0, 1'b1);
    drive(1'b1, 32'hE000_2030, 1'b0, 4'h0, 32'h22, 1'b1, 1'b1);
    idle(15);
    check("abort_acc_count", n_acc - a0, 1);
    check("abort_rsp_count", n_rsp - r0, 1);
    check("abort_survivor_tag", last_tag, 9'h022);

    check("ovf_initial", err_ovf, 0);
    stall = 1'b1; a0 = n_acc;
    for (int i = 0; i < 6; i++)
      drive(1'b1, {16'hE000, 2'b00, 2'(i % 4), 12'(4 * i)}, 1'b1, 4'hF, 32'(32'h100 + i), 1'b0, 1'(i < 5));
    idle(20);
    stall = 1'b0;
    idle(20);
    check("ovf_acc_count", n_acc - a0, 5);
    check("ovf_flag", err_ovf, 1);
    clear_errors();
    check("ovf_clear", err_ovf, 0);

    stall = 1'b1; r0 = n_rsp; q0 = req_cycles;
    exp_rsp.push_back('{32'hFFFF_FFFF, 9'h007});
    drive(1'b1, 32'hE000_1000, 1'b0, 4'h0, 32'h7, 1'b0, 1'b0);
    for (int k = 0; k < 300 && n_rsp == r0; k++) idle(1);
    check("to_rsp_count", n_rsp - r0, 1);
    check("to_req_cycles", req_cycles - q0, 255);
    check("to_flag", err_to, 1);
    stall = 1'b0;
    clear_errors();
    check("to_clear", err_to, 0);

    pdly_max = 2;
    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(4) != 0) a[31:16] = 16'hE000;
      drive(1'b1, a, 1'($urandom_range(1)), 4'($urandom), $urandom, 1'b0, 1'b1);
      drive(1'b0, '0, 1'b0, '0, '0, 1'($urandom_range(4) == 0), 1'b0);
      idle(8 + int'($urandom_range(4)));
    end
    idle(20);
    check("rand_acc_drained", exp_acc.size(), 0);
    check("rand_rsp_drained", exp_rsp.size(), 0);
    check("rand_no_errors", {err_ovf, err_to}, 0);

    stall = 1'b1; r0 = n_rsp;
    drive(1'b1, 32'hE000_2000, 1'b0, 4'h0, 32'h1AB, 1'b0, 1'b0);
    idle(1);
    for (int k = 0; k < 10 && !per_if.request; k++) idle(1);
    check("rst_reached_issue", per_if.request, 1);
    #2 rst_n = 1'b0;
    #1 check("rst_async_drop", {per_if.request, per_if.sel}, 0);
    idle(3);
    check("rst_outputs", {cpu_if.rvalid, cpu_if.rdata, cpu_if.rtag, per_if.request, per_if.sel, per_if.addr,
                          per_if.write, per_if.wstrb, per_if.wdata, err_ovf, err_to}, 0);
    rst_n = 1'b1; stall = 1'b0;
    idle(20);
    check("rst_no_response", n_rsp - r0, 0);
    check("rst_idle_after", per_if.request, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
